// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Byte lanes per instruction-memory write word.
  localparam int WR_BYTES          = 4;
  // Width of the lane index inside the packer.
  localparam int LANE_W            = 2;
  // Width of the "valid bytes minus one" write qualifier.
  localparam int SHIFT_W           = 2;
  // Default instruction-memory capacity in bytes.
  localparam int MAX_BYTES_DEFAULT = 4096;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs a byte stream little-endian into write words. The packing register
// and the write-output register are separate so a word can be issued while
// the next byte is already being packed.
module byte_packer
  import instr_loader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [7:0]         i_byte,
  input  logic               i_last,
  output logic               o_wr_vld,
  output logic [W-1:0]       o_wr_data,
  output logic [SHIFT_W-1:0] o_shift_m1
);

  logic [W-1:0]       r_pack;
  logic [LANE_W-1:0]  r_lane;
  logic               r_wr_vld;
  logic [W-1:0]       r_wr_data;
  logic [SHIFT_W-1:0] r_shift;
  logic [W-1:0]       w_word;
  logic               w_flush;

  // Merge the incoming byte into its lane; flush on a full word or last byte.
  always_comb begin
    w_word  = r_pack | (W'(i_byte) << {r_lane, 3'b000});
    w_flush = (r_lane == LANE_W'(WR_BYTES - 1)) | i_last;
  end

  // Packing register, lane index and one-cycle write-output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pack    <= '0;
      r_lane    <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_data <= '0;
      r_shift   <= '0;
    end else begin
      r_wr_vld <= 1'b0;
      if (i_clear) begin
        r_pack <= '0;
        r_lane <= '0;
      end else if (i_push) begin
        if (w_flush) begin
          r_wr_vld  <= 1'b1;
          r_wr_data <= w_word;
          r_shift   <= SHIFT_W'(r_lane);
          r_pack    <= '0;
          r_lane    <= '0;
        end else begin
          r_pack <= w_word;
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  assign o_wr_vld   = r_wr_vld;
  assign o_wr_data  = r_wr_data;
  assign o_shift_m1 = r_shift;

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts a host program byte stream, writes it into
// instruction memory a word at a time, then releases the CPU and waits for
// it to report the end of the program.
// Byte handshake: a byte moves when i_byte_vld and o_byte_rdy are both high
// on a rising clock edge; i_byte_last only has meaning on such an edge.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int INSTR_WRITE_WIDTH = 32,
  parameter int BYTE_CNT_W        = 12,
  parameter int MAX_BYTES         = MAX_BYTES_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [7:0]                   i_byte,
  input  logic                         i_byte_vld,
  input  logic                         i_byte_last,
  output logic                         o_byte_rdy,
  output logic                         o_wr_req_vld,
  output logic [INSTR_WRITE_WIDTH-1:0] o_wr_data,
  output logic [SHIFT_W-1:0]           o_write_pointer_shift_minusone,
  input  logic                         i_instr_finish,
  output logic                         o_cpu_run,
  output logic                         o_done,
  output logic                         o_load_error,
  output logic [BYTE_CNT_W-1:0]        o_byte_count
);

  // One extra bit so the counter can hold MAX_BYTES even when it equals
  // 2**BYTE_CNT_W; the port then reads as all-ones.
  localparam int CNT_W = BYTE_CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

  state_e           r_state;
  logic             r_byte_rdy;
  logic             r_cpu_run;
  logic             r_done;
  logic             r_load_error;
  logic             r_last_seen;
  logic [CNT_W-1:0] r_count;

  logic w_accept;
  logic w_full;
  logic w_push;
  logic w_start_ok;
  logic w_clear;

  // Handshake, capacity check and packer control.
  always_comb begin
    w_accept   = i_byte_vld & r_byte_rdy;
    w_full     = (r_count == CNT_MAX);
    w_push     = w_accept & ~w_full;
    w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE) |
                            (r_state == ST_ERR));
    w_clear    = w_start_ok | (w_accept & w_full);
  end

  // Load sequencing FSM with registered status outputs and byte counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_byte_rdy   <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_done       <= 1'b0;
      r_load_error <= 1'b0;
      r_last_seen  <= 1'b0;
      r_count      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_start) begin
            r_state      <= ST_LOAD;
            r_byte_rdy   <= 1'b1;
            r_count      <= '0;
            r_load_error <= 1'b0;
            r_done       <= 1'b0;
            r_last_seen  <= 1'b0;
          end
        end
        ST_LOAD: begin
          // The final word is on the write port this cycle; run next.
          if (r_last_seen) begin
            r_state     <= ST_RUN;
            r_cpu_run   <= 1'b1;
            r_last_seen <= 1'b0;
          end else if (w_accept) begin
            if (w_full) begin
              r_state      <= ST_ERR;
              r_load_error <= 1'b1;
              r_byte_rdy   <= 1'b0;
            end else begin
              r_count <= r_count + CNT_W'(1);
              if (i_byte_last) begin
                r_byte_rdy  <= 1'b0;
                r_last_seen <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (i_instr_finish) begin
            r_state   <= ST_DONE;
            r_cpu_run <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  byte_packer #(
    .W (INSTR_WRITE_WIDTH)
  ) u_packer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_push     (w_push),
    .i_byte     (i_byte),
    .i_last     (i_byte_last),
    .o_wr_vld   (o_wr_req_vld),
    .o_wr_data  (o_wr_data),
    .o_shift_m1 (o_write_pointer_shift_minusone)
  );

  assign o_byte_rdy   = r_byte_rdy;
  assign o_cpu_run    = r_cpu_run;
  assign o_done       = r_done;
  assign o_load_error = r_load_error;
  assign o_byte_count = r_count[CNT_W-1] ? {BYTE_CNT_W{1'b1}}
                                         : r_count[BYTE_CNT_W-1:0];

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances share all inputs, one at default
// capacity (A) and one with an 8-byte capacity (B).
module tb_instr_loader;

  localparam int B_MAX = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte = '0;
  logic        i_byte_vld = 1'b0;
  logic        i_byte_last = 1'b0;
  logic        i_instr_finish = 1'b0;

  logic        a_rdy, a_wv, a_run, a_done, a_err;
  logic [31:0] a_wd;
  logic [1:0]  a_sh;
  logic [11:0] a_cnt;
  logic        b_rdy, b_wv, b_run, b_done, b_err;
  logic [31:0] b_wd;
  logic [1:0]  b_sh;
  logic [11:0] b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] exp_qa[$];
  logic [33:0] exp_qb[$];
  logic [7:0]  bytes_buf[64];

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          nw;
    logic [31:0] w0;
    logic [1:0]  s0;
    logic [31:0] w1;
    logic [1:0]  s1;
  } vec_t;
  vec_t tbl[4];

  instr_loader u_dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_byte(i_byte),
    .i_byte_vld(i_byte_vld), .i_byte_last(i_byte_last), .o_byte_rdy(a_rdy),
    .o_wr_req_vld(a_wv), .o_wr_data(a_wd), .o_write_pointer_shift_minusone(a_sh),
    .i_instr_finish(i_instr_finish), .o_cpu_run(a_run), .o_done(a_done),
    .o_load_error(a_err), .o_byte_count(a_cnt)
  );

  instr_loader #(.MAX_BYTES(B_MAX)) u_dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_byte(i_byte),
    .i_byte_vld(i_byte_vld), .i_byte_last(i_byte_last), .o_byte_rdy(b_rdy),
    .o_wr_req_vld(b_wv), .o_wr_data(b_wd), .o_write_pointer_shift_minusone(b_sh),
    .i_instr_finish(i_instr_finish), .o_cpu_run(b_run), .o_done(b_done),
    .o_load_error(b_err), .o_byte_count(b_cnt)
  );

  // Clock and global time limit.
  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboards: every write strobe must match the next expected word.
  always @(negedge i_clk) begin
    if (a_wv) begin
      if (exp_qa.size() == 0) check("a_unexpected_write", {a_sh, a_wd}, 0);
      else check("a_write", {a_sh, a_wd}, exp_qa.pop_front());
    end
    if (b_wv) begin
      if (exp_qb.size() == 0) check("b_unexpected_write", {b_sh, b_wd}, 0);
      else check("b_write", {b_sh, b_wd}, exp_qb.pop_front());
    end
  end

  // Reference model: chop the program into 4-byte words. Bytes beyond the
  // capacity raise an error, and a partial word pending at that point is lost.
  task automatic model_expect(input int n);
    for (int inst = 0; inst < 2; inst++) begin
      int lim  = (inst == 1) ? B_MAX : 4096;
      bit err  = (n > lim);
      int good = err ? lim : n;
      for (int w = 0; w * 4 < good; w++) begin
        int lanes = (good - 4 * w) > 4 ? 4 : (good - 4 * w);
        logic [31:0] data = '0;
        if (err && lanes < 4) continue;
        for (int k = 0; k < lanes; k++) data[8*k +: 8] = bytes_buf[4*w + k];
        if (inst == 1) exp_qb.push_back({2'(lanes - 1), data});
        else exp_qa.push_back({2'(lanes - 1), data});
      end
    end
  endtask

  task automatic begin_load();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("a_start_cnt", a_cnt, 0);
    check("b_start_cnt", b_cnt, 0);
    check("start_err", {a_err, b_err, a_done, b_done}, 0);
    check("start_rdy", {a_rdy, b_rdy}, 2'b11);
  endtask

  // Drive bytes_buf[first..n-1]; optional idle gaps carry junk data/last.
  task automatic send_bytes(input int first, input int n, input bit gap, input bit with_last);
    for (int i = first; i < n; i++) begin
      if (gap) begin
        int g = $urandom_range(0, 3);
        repeat (g) begin
          i_byte_vld  = 1'b0;
          i_byte      = 8'($urandom);
          i_byte_last = 1'($urandom);
          @(posedge i_clk); #1;
        end
      end
      i_byte_vld  = 1'b1;
      i_byte      = bytes_buf[i];
      i_byte_last = with_last && (i == n - 1);
      begin
        int t = 0;
        while (!a_rdy && t < 20) begin
          @(posedge i_clk); #1;
          t++;
        end
      end
      check("a_rdy_wait", a_rdy, 1);
      @(posedge i_clk); #1;
    end
    i_byte_vld  = 1'b0;
    i_byte_last = 1'b0;
  endtask

  // Called #1 after the edge that accepted the last byte.
  task automatic finish_load(input int n, input bit with_start);
    bit berr = (n > B_MAX);
    check("a_rdy_after_last", a_rdy, 0);
    check("a_run_during_write", a_run, 0);
    @(posedge i_clk); #1;
    check("a_run", a_run, 1);
    check("b_run", b_run, !berr);
    repeat (2) @(posedge i_clk);
    #1;
    check("a_q_drained", exp_qa.size(), 0);
    check("b_q_drained", exp_qb.size(), 0);
    check("a_count", a_cnt, n);
    check("b_count", b_cnt, berr ? B_MAX : n);
    check("errs", {a_err, b_err}, {1'b0, berr});
    i_instr_finish = 1'b1;
    i_start        = with_start;
    @(posedge i_clk); #1;
    i_instr_finish = 1'b0;
    i_start        = 1'b0;
    check("a_done", {a_done, a_run}, 2'b10);
    check("b_done", {b_done, b_run, b_err}, {!berr, 1'b0, berr});
    if (with_start) begin
      repeat (2) @(posedge i_clk);
      #1;
      check("no_reload", {a_rdy, a_done, a_cnt}, {2'b01, 12'(n)});
    end
  endtask

  initial begin
    tbl[0] = '{4, 64'h000000006A052041, 1, 32'h6A052041, 2'd3, 32'h0, 2'd0};
    tbl[1] = '{6, 64'h0000060504030201, 2, 32'h04030201, 2'd3, 32'h00000605, 2'd1};
    tbl[2] = '{1, 64'h0000000000000099, 1, 32'h00000099, 2'd0, 32'h0, 2'd0};
    tbl[3] = '{7, 64'h0077665544332211, 2, 32'h44332211, 2'd3, 32'h00776655, 2'd2};

    // Reset values.
    #3;
    check("a_reset_outs", {a_rdy, a_wv, a_sh, a_run, a_done, a_err, a_cnt, a_wd}, 0);
    check("b_reset_outs", {b_rdy, b_wv, b_sh, b_run, b_done, b_err, b_cnt, b_wd}, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed table; the first entry also exercises start+finish together in RUN.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < tbl[v].n; k++) bytes_buf[k] = tbl[v].bytes[8*k +: 8];
      begin_load();
      exp_qa.push_back({tbl[v].s0, tbl[v].w0});
      exp_qb.push_back({tbl[v].s0, tbl[v].w0});
      if (tbl[v].nw > 1) begin
        exp_qa.push_back({tbl[v].s1, tbl[v].w1});
        exp_qb.push_back({tbl[v].s1, tbl[v].w1});
      end
      send_bytes(0, tbl[v].n, 1'b0, 1'b1);
      finish_load(tbl[v].n, v == 0);
    end

    // Capacity overflow on B with 9 bytes; A loads them all.
    for (int k = 0; k < 9; k++) bytes_buf[k] = 8'(8'hA0 + k);
    begin_load();
    model_expect(9);
    send_bytes(0, 9, 1'b0, 1'b1);
    finish_load(9, 1'b0);

    // Start, finish and a stray last flag mid-load are ignored.
    for (int k = 0; k < 6; k++) bytes_buf[k] = 8'($urandom);
    begin_load();
    model_expect(6);
    send_bytes(0, 2, 1'b0, 1'b0);
    i_start = 1'b1; i_instr_finish = 1'b1; i_byte_last = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_instr_finish = 1'b0; i_byte_last = 1'b0;
    check("a_load_ignores_start", {a_cnt, a_rdy, a_run}, {12'd2, 2'b10});
    send_bytes(2, 6, 1'b0, 1'b1);
    finish_load(6, 1'b0);

    // Reset in the middle of a word.
    for (int k = 0; k < 2; k++) bytes_buf[k] = 8'($urandom);
    begin_load();
    send_bytes(0, 2, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("a_midreset_outs", {a_rdy, a_wv, a_sh, a_run, a_done, a_err, a_cnt, a_wd}, 0);
    check("b_midreset_outs", {b_rdy, b_wv, b_sh, b_run, b_done, b_err, b_cnt, b_wd}, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (8) @(posedge i_clk);
    #1;
    check("idle_after_reset", {a_rdy, b_rdy, a_cnt}, 0);

    // Ten bytes with randomly toggling valid.
    for (int k = 0; k < 10; k++) bytes_buf[k] = 8'($urandom);
    begin_load();
    model_expect(10);
    send_bytes(0, 10, 1'b1, 1'b1);
    finish_load(10, 1'b0);

    // Random loads against the model.
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) bytes_buf[k] = 8'($urandom);
      begin_load();
      model_expect(n);
      send_bytes(0, n, 1'($urandom), 1'b1);
      finish_load(n, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
